// File: rtl/updown_arb_pkg.sv
// Shared types and the round-robin pick helper for the up/down counter arbiter.
package updown_arb_pkg;

    localparam int          NUM_REQ_DEF = 4;
    localparam int          CNT_W_DEF   = 3;
    localparam int unsigned MAX_REQ     = 32'd32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // First asserted request scanning upward from last_ptr+1 with wrap; n is the requester count.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                            input int unsigned        last_ptr,
                                            input int unsigned        n);
        int unsigned idx;
        logic        found;
        found   = 1'b0;
        idx     = 32'd0;
        rr_pick = 32'd0;
        for (int unsigned k = 32'd1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = (last_ptr + k) % n;
                if (!found && req[idx[4:0]]) begin
                    found   = 1'b1;
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/updown_counter.sv
// Saturating up/down counter; Up wins when both pulses arrive together.
module updown_counter
    import updown_arb_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clock_i,
    input  logic             Reset_i,
    input  logic             Up_i,
    input  logic             Down_i,
    output logic [CNT_W-1:0] Count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [CNT_W-1:0] r_count;

    // Count register: step only when the boundary allows it, otherwise hold.
    always_ff @(posedge Clock_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_count <= CNT_ZERO;
        end else if (Up_i) begin
            if (r_count != CNT_MAX) begin
                r_count <= r_count + CNT_ONE;
            end
        end else if (Down_i) begin
            if (r_count != CNT_ZERO) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    assign Count_o = r_count;

endmodule

// File: rtl/updown_counter_arbiter.sv
// Round-robin req/grant front end sharing one saturating up/down counter among NUM_REQ clients.
module updown_counter_arbiter
    import updown_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               Clock_i,
    input  logic               Reset_i,
    input  logic [NUM_REQ-1:0] Req_i,
    input  logic [NUM_REQ-1:0] Dir_i,
    output logic [NUM_REQ-1:0] Grant_o,
    output logic [NUM_REQ-1:0] Nack_o,
    output logic [CNT_W-1:0]   Count_o,
    output logic               Busy_o
);

    localparam int                 PTR_W     = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0]   COUNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [NUM_REQ-1:0] REQ_ZERO  = {NUM_REQ{1'b0}};
    localparam logic [NUM_REQ-1:0] REQ_ONE   = NUM_REQ'(1'b1);
    localparam logic [PTR_W-1:0]   LAST_RST  = PTR_W'(NUM_REQ - 1);

    arb_state_t         r_state, w_next_state;
    logic [PTR_W-1:0]   r_sel, r_last_ptr, w_pick;
    logic               r_dir, r_accept, r_busy;
    logic [NUM_REQ-1:0] r_grant, r_nack, w_next_grant, w_next_nack, w_onehot;
    logic               w_pick_dir, w_can_move, w_load, w_up, w_down;
    logic [CNT_W-1:0]   w_count;

    assign w_pick     = PTR_W'(rr_pick(MAX_REQ'(Req_i), 32'(r_last_ptr), 32'(NUM_REQ)));
    assign w_pick_dir = Dir_i[w_pick];
    assign w_onehot   = REQ_ONE << w_pick;
    // Decision is taken at arbitration so Grant/Nack can be registered into the ISSUE cycle.
    assign w_can_move = w_pick_dir ? (w_count != COUNT_MAX) : (w_count != CNT_ZERO);

    // Next-state, handshake outputs and the single counter pulse issued in ISSUE.
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_nack  = r_nack;
        w_load       = 1'b0;
        w_up         = 1'b0;
        w_down       = 1'b0;
        case (r_state)
            IDLE: begin
                if (|Req_i) begin
                    w_next_state = ISSUE;
                    w_load       = 1'b1;
                    if (w_can_move) begin
                        w_next_grant = w_onehot;
                    end else begin
                        w_next_nack = w_onehot;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                w_next_state = RELEASE;
                if (r_accept) begin
                    w_up   = r_dir;
                    w_down = ~r_dir;
                end else begin
                    w_up   = 1'b0;
                    w_down = 1'b0;
                end
            end
            RELEASE: begin
                if (!Req_i[r_sel]) begin
                    w_next_state = IDLE;
                    w_next_grant = REQ_ZERO;
                    w_next_nack  = REQ_ZERO;
                end else begin
                    w_next_state = RELEASE;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_grant = REQ_ZERO;
                w_next_nack  = REQ_ZERO;
            end
        endcase
    end

    // State, captured transaction and registered outputs.
    always_ff @(posedge Clock_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_state    <= IDLE;
            r_sel      <= {PTR_W{1'b0}};
            r_dir      <= 1'b0;
            r_accept   <= 1'b0;
            r_last_ptr <= LAST_RST;
            r_grant    <= REQ_ZERO;
            r_nack     <= REQ_ZERO;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_grant <= w_next_grant;
            r_nack  <= w_next_nack;
            r_busy  <= (w_next_state != IDLE);
            if (w_load) begin
                r_sel    <= w_pick;
                r_dir    <= w_pick_dir;
                r_accept <= w_can_move;
            end
            if (r_state == ISSUE) begin
                r_last_ptr <= r_sel;
            end
        end
    end

    updown_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .Clock_i(Clock_i),
        .Reset_i(Reset_i),
        .Up_i   (w_up),
        .Down_i (w_down),
        .Count_o(w_count)
    );

    assign Grant_o = r_grant;
    assign Nack_o  = r_nack;
    assign Count_o = w_count;
    assign Busy_o  = r_busy;

endmodule
